display_scan_controller: RTL



---
 rtl/display_pkg.sv | 15 +
 rtl/slot_timer.sv | 26 ++
 rtl/display_scan_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types for the seven-segment display datapath
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [NUM_DIGITS-1:0] digit_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - per-slot cycle counter, wraps every SLOT_CYCLES
module slot_timer #(
  parameter int SLOT_CYCLES = 25000,
  localparam int TW = $clog2(SLOT_CYCLES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  input  logic          clear,
  output logic [TW-1:0] count,
  output logic          slot_end
);

  assign slot_end = run && (count == TW'(SLOT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= slot_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - digit scan FSM with dead-time, masking and PWM
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SLOT_CYCLES  = 25000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] digit_mask,
  input  logic [3:0] brightness,
  output digit_sel_t selector,
  output logic [3:0] anode_n,
  output logic [1:0] slot_index,
  output logic       frame_done
);

  localparam int TW = $clog2(SLOT_CYCLES);
  localparam int CW = TW + 5;

  generate
    if (SLOT_CYCLES <= BLANK_CYCLES || BLANK_CYCLES < 1) begin : g_bad_params
      $error("display_scan_controller: need SLOT_CYCLES > BLANK_CYCLES >= 1");
    end
  endgenerate

  scan_state_t   state_q, state_d;
  logic [1:0]    slot_q, slot_d;
  logic [3:0]    mask_q, brightness_q;
  logic          load;
  logic          frame_done_d;
  logic [TW-1:0] count;
  logic          slot_end;
  logic [CW-1:0] prod, on_cycles, on_end;

  slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_slot_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (enable),
    .clear    (state_q == IDLE || !enable),
    .count    (count),
    .slot_end (slot_end)
  );

  assign prod      = CW'(SLOT_CYCLES - BLANK_CYCLES) * CW'({1'b0, brightness_q} + 5'd1);
  assign on_cycles = prod >> 4;
  assign on_end    = CW'(BLANK_CYCLES) + on_cycles - CW'(1);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    load    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      slot_d  = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          slot_d  = 2'd0;
          load    = 1'b1;
        end
        default: begin
          // Slot end wins over ON->OFF so full brightness runs to the slot boundary.
          if (slot_end) begin
            state_d = BLANK;
            slot_d  = slot_q + 2'd1;
            load    = (slot_q == 2'd3);
          end else begin
            case (state_q)
              BLANK: if (count == TW'(BLANK_CYCLES - 1))
                state_d = (on_cycles == '0) ? OFF : ON;
              ON: if ({5'b0, count} == on_end)
                state_d = OFF;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // The counter advances every enabled cycle, so S-2 now means S-1 on the registered output.
  assign frame_done_d = enable && (state_q != IDLE) && (slot_q == 2'd3)
                        && (count == TW'(SLOT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      slot_q       <= 2'd0;
      mask_q       <= 4'b0000;
      brightness_q <= 4'd0;
      selector     <= 4'b0001;
      anode_n      <= 4'b1111;
      frame_done   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      if (load) begin
        mask_q       <= digit_mask;
        brightness_q <= brightness;
      end
      selector   <= 4'b0001 << slot_d;
      anode_n    <= (state_d == ON && mask_q[slot_d]) ? ~(4'b0001 << slot_d) : 4'b1111;
      frame_done <= frame_done_d;
    end
  end

  assign slot_index = slot_q;

endmodule
